pc_unit: RTL and testbench

- Parametrised, registered PC generator for the pipelined CPU. Generalises the combinational next-PC adder with:
  - a PC register and a valid/ready fetch-request handshake to instruction memory;
  - branch/jump redirect with a JALR bit-0 clear;
  - trap redirect with direct or vectored trap-vector modes;
  - a one-entry pending-redirect buffer, used when a redirect arrives while a fetch is back-pressured;
  - misaligned-target detection.
- Sits between the execute/trap logic and the I-memory port.

---
 rtl/pc_unit_if.sv | 12 +
 rtl/pc_unit.sv | 98 +++++++++
 tb/tb_pc_unit.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/pc_unit_if.sv
// Fetch-request channel between the PC generator and instruction memory.
// The PC side drives valid/address; the memory side answers with ready.
interface pc_unit_if #(
   parameter int XLEN = 32
);
   logic            req_valid;
   logic            req_ready;
   logic [XLEN-1:0] req_addr;

   modport master (output req_valid, output req_addr, input req_ready);
   modport slave  (input req_valid, input req_addr, output req_ready);
endinterface

// File: rtl/pc_unit.sv
// Registered PC generator: sequential fetch, branch/JALR and trap redirects,
// a one-entry redirect buffer for back-pressured fetches, misalign reporting.
module pc_unit #(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_VEC = '0,
   parameter int              STEP      = 4,
   parameter int              CAUSE_W   = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   pc_unit_if.master          fetch,
   input  logic               i_br_valid,
   input  logic               i_br_base_sel,
   input  logic [XLEN-1:0]    i_br_pc,
   input  logic [XLEN-1:0]    i_rs1,
   input  logic [XLEN-1:0]    i_imm,
   input  logic               i_trap_valid,
   input  logic [XLEN-1:0]    i_tvec,
   input  logic [CAUSE_W-1:0] i_trap_cause,
   output logic               o_pending,
   output logic               o_misalign_err,
   output logic [XLEN-1:0]    o_misalign_addr
);

   logic [XLEN-1:0] r_pc;
   logic            r_req_valid;
   logic            r_pending;
   logic [XLEN-1:0] r_pend_tgt;
   logic            r_misalign_err;
   logic [XLEN-1:0] r_misalign_addr;

   logic [XLEN-1:0] w_br_base;
   logic [XLEN-1:0] w_br_sum;
   logic [XLEN-1:0] w_br_tgt;
   logic            w_br_misalign;
   logic [XLEN-1:0] w_tvec_base;
   logic [XLEN-1:0] w_cause_off;
   logic [XLEN-1:0] w_trap_tgt;
   logic            w_event;
   logic [XLEN-1:0] w_event_tgt;
   logic            w_fire;
   logic            w_misalign_now;

   assign w_br_base     = i_br_base_sel ? i_rs1 : i_br_pc;
   assign w_br_sum      = w_br_base + i_imm;
   // JALR clears bit 0 before the alignment test
   assign w_br_tgt      = i_br_base_sel ? {w_br_sum[XLEN-1:1], 1'b0} : w_br_sum;
   assign w_br_misalign = w_br_tgt[1];

   assign w_tvec_base = {i_tvec[XLEN-1:2], 2'b00};
   assign w_cause_off = {{(XLEN-CAUSE_W-2){1'b0}}, i_trap_cause, 2'b00};
   assign w_trap_tgt  = (i_tvec[1:0] == 2'b01) ? (w_tvec_base + w_cause_off) : w_tvec_base;

   assign w_event        = i_trap_valid | (i_br_valid & ~w_br_misalign);
   assign w_event_tgt    = i_trap_valid ? w_trap_tgt : w_br_tgt;
   assign w_misalign_now = i_br_valid & ~i_trap_valid & w_br_misalign;
   assign w_fire         = r_req_valid & fetch.req_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc            <= RESET_VEC;
         r_req_valid     <= 1'b0;
         r_pending       <= 1'b0;
         r_pend_tgt      <= '0;
         r_misalign_err  <= 1'b0;
         r_misalign_addr <= '0;
      end else begin
         r_req_valid    <= 1'b1;
         r_misalign_err <= w_misalign_now;
         if (w_misalign_now)
            r_misalign_addr <= w_br_tgt;

         if (w_event) begin
            if (!r_req_valid || w_fire) begin
               r_pc      <= w_event_tgt;
               r_pending <= 1'b0;
            end else begin
               r_pend_tgt <= w_event_tgt;
               r_pending  <= 1'b1;
            end
         end else if (w_fire) begin
            if (r_pending) begin
               r_pc      <= r_pend_tgt;
               r_pending <= 1'b0;
            end else begin
               r_pc <= r_pc + XLEN'(STEP);
            end
         end
      end
   end

   assign fetch.req_valid = r_req_valid;
   assign fetch.req_addr  = r_pc;
   assign o_pending       = r_pending;
   assign o_misalign_err  = r_misalign_err;
   assign o_misalign_addr = r_misalign_addr;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios followed by random traffic, all
// compared every cycle against a behavioural fetch-address model.
module tb_pc_unit;

   logic        clk;
   logic        rst_n;
   logic        br_valid;
   logic        br_base_sel;
   logic [31:0] br_pc;
   logic [31:0] rs1;
   logic [31:0] imm;
   logic        trap_valid;
   logic [31:0] tvec;
   logic [4:0]  trap_cause;
   logic        pending;
   logic        misalign_err;
   logic [31:0] misalign_addr;

   pc_unit_if #(.XLEN(32)) fif ();

   pc_unit #(.XLEN(32), .RESET_VEC(32'h0), .STEP(4), .CAUSE_W(5)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .fetch          (fif),
      .i_br_valid     (br_valid),
      .i_br_base_sel  (br_base_sel),
      .i_br_pc        (br_pc),
      .i_rs1          (rs1),
      .i_imm          (imm),
      .i_trap_valid   (trap_valid),
      .i_tvec         (tvec),
      .i_trap_cause   (trap_cause),
      .o_pending      (pending),
      .o_misalign_err (misalign_err),
      .o_misalign_addr(misalign_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // model state: what the fetch port should look like right now
   logic [31:0] m_pc;
   logic        m_valid;
   logic        m_pend;
   logic [31:0] m_ptgt;
   logic        m_merr;
   logic [31:0] m_maddr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("req_valid", {31'b0, fif.req_valid}, {31'b0, m_valid});
      chk("req_addr", fif.req_addr, m_pc);
      chk("pending", {31'b0, pending}, {31'b0, m_pend});
      chk("misalign_err", {31'b0, misalign_err}, {31'b0, m_merr});
      if (m_merr) chk("misalign_addr", misalign_addr, m_maddr);
   endtask

   task automatic model_reset();
      m_pc = 32'h0; m_valid = 1'b0; m_pend = 1'b0; m_ptgt = 32'h0;
      m_merr = 1'b0; m_maddr = 32'h0;
   endtask

   // One clock: predict from current inputs, advance, compare, drop pulses.
   task automatic tick();
      logic        fire, bad, redirect;
      logic [31:0] btgt, ttgt, tgt;
      logic [31:0] n_pc, n_ptgt, n_maddr;
      logic        n_pend, n_merr;
      fire = m_valid && fif.req_ready;
      btgt = (br_base_sel ? rs1 : br_pc) + imm;
      if (br_base_sel) btgt = btgt & ~32'h1;
      bad  = (btgt % 4) >= 2;
      ttgt = (tvec & ~32'h3) + ((tvec % 4 == 1) ? trap_cause * 4 : 32'h0);
      redirect = trap_valid || (br_valid && !bad);
      tgt  = trap_valid ? ttgt : btgt;
      n_pc = m_pc; n_pend = m_pend; n_ptgt = m_ptgt;
      n_merr = br_valid && !trap_valid && bad;
      n_maddr = n_merr ? btgt : m_maddr;
      if (redirect && (!m_valid || fire)) begin n_pc = tgt; n_pend = 1'b0; end
      else if (redirect) begin n_ptgt = tgt; n_pend = 1'b1; end
      else if (fire && m_pend) begin n_pc = m_ptgt; n_pend = 1'b0; end
      else if (fire) n_pc = m_pc + 32'd4;
      @(posedge clk);
      #1;
      if (rst_n) begin
         m_pc = n_pc; m_valid = 1'b1; m_pend = n_pend; m_ptgt = n_ptgt;
         m_merr = n_merr; m_maddr = n_maddr;
      end else model_reset();
      br_valid = 1'b0; trap_valid = 1'b0;
      check_all();
   endtask

   task automatic branch(input logic sel, input logic [31:0] pc, input logic [31:0] r,
                         input logic [31:0] im);
      br_valid = 1'b1; br_base_sel = sel; br_pc = pc; rs1 = r; imm = im;
   endtask

   initial begin
      rst_n = 1'b0; fif.req_ready = 1'b0;
      br_valid = 0; br_base_sel = 0; br_pc = 0; rs1 = 0; imm = 0;
      trap_valid = 0; tvec = 0; trap_cause = 0;
      model_reset();
      #12;
      check_all();
      rst_n = 1'b1;
      #1;

      // sequential start: first edge only raises valid
      fif.req_ready = 1'b1;
      tick(); chk("seq0", fif.req_addr, 32'h0);
      tick(); chk("seq1", fif.req_addr, 32'h4);
      tick(); chk("seq2", fif.req_addr, 32'h8);

      branch(1'b0, 32'h0, 32'h0, 32'h100); tick(); chk("br_to_100", fif.req_addr, 32'h100);
      branch(1'b0, 32'hF8, 32'h0, 32'h20); tick(); chk("br_118", fif.req_addr, 32'h118);
      branch(1'b1, 32'h0, 32'h2001, 32'h0); tick(); chk("jalr_2000", fif.req_addr, 32'h2000);

      // redirect while stalled goes to the pending buffer
      branch(1'b0, 32'h40, 32'h0, 32'h0); tick(); chk("br_40", fif.req_addr, 32'h40);
      fif.req_ready = 1'b0;
      branch(1'b0, 32'h80, 32'h0, 32'h0); tick();
      chk("stall_addr", fif.req_addr, 32'h40); chk("stall_pend", {31'b0, pending}, 32'h1);
      tick(); chk("stall_hold", fif.req_addr, 32'h40);
      fif.req_ready = 1'b1; tick();
      chk("pend_drain", fif.req_addr, 32'h80); chk("pend_clr", {31'b0, pending}, 32'h0);

      // trap beats a simultaneous branch
      trap_valid = 1'b1; tvec = 32'h1001; trap_cause = 5'd3;
      branch(1'b0, 32'h500, 32'h0, 32'h0); tick(); chk("trap_vec", fif.req_addr, 32'h100C);
      trap_valid = 1'b1; tvec = 32'h1000;
      branch(1'b0, 32'h500, 32'h0, 32'h0); tick(); chk("trap_dir", fif.req_addr, 32'h1000);

      // misaligned JALR: PC keeps stepping, error pulses once
      branch(1'b1, 32'h0, 32'h202, 32'h0); tick();
      chk("mis_step", fif.req_addr, 32'h1004);
      chk("mis_err", {31'b0, misalign_err}, 32'h1);
      chk("mis_addr", misalign_addr, 32'h202);
      tick(); chk("mis_pulse", {31'b0, misalign_err}, 32'h0);

      // wrap-around, then reset kills a pending redirect
      branch(1'b0, 32'hFFFF_FFF0, 32'h0, 32'hC); tick(); chk("pc_top", fif.req_addr, 32'hFFFF_FFFC);
      tick(); chk("wrap", fif.req_addr, 32'h0);
      fif.req_ready = 1'b0;
      branch(1'b0, 32'h300, 32'h0, 32'h0); tick(); chk("pend_before_rst", {31'b0, pending}, 32'h1);
      #2 rst_n = 1'b0; #1;
      model_reset();
      chk("rst_pend", {31'b0, pending}, 32'h0);
      chk("rst_addr", fif.req_addr, 32'h0);
      chk("rst_valid", {31'b0, fif.req_valid}, 32'h0);
      tick();
      #2 rst_n = 1'b1;

      // random traffic
      for (int i = 0; i < 400; i++) begin
         fif.req_ready = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 4) == 0)
            branch(1'($urandom), $urandom, $urandom, 32'($urandom_range(0, 64)) - 32'd32);
         if ($urandom_range(0, 9) == 0) begin
            trap_valid = 1'b1; tvec = $urandom; trap_cause = 5'($urandom);
         end
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
